// File: rtl/seven_segment_scan_decoder.sv
// Receiver-side monitor for a multiplexed active-low seven-segment display.
// Filters scan transitions, decodes committed patterns back to BCD, and tracks frames and protocol errors.
module seven_segment_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_data,
    input  logic [3:0]  seg_enable,
    input  logic        err_clear,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  digit_updated,
    output logic        frame_valid,
    output logic [15:0] frame_digits,
    output logic        err_pattern,
    output logic        err_enable
);

    localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

    logic [11:0] r_key;
    logic [7:0]  r_count;
    logic        r_commitPend;
    logic [1:0]  r_commitSlot;
    logic [7:0]  r_commitSeg;
    logic [3:0]  r_seen;

    logic [11:0] w_key;
    logic        w_keyChanged;
    logic        w_legal;
    logic        w_multi;
    logic [1:0]  w_slot;
    logic [7:0]  w_nextCount;
    logic        w_startCommit;
    logic [3:0]  w_nibble;
    logic        w_badPattern;
    logic        w_patternErr;
    logic [15:0] w_digitsNext;
    logic [3:0]  w_seenNext;

    assign w_key        = {seg_enable, seg_data};
    assign w_keyChanged = (w_key != r_key);

    always_comb begin
        w_legal = 1'b0;
        w_multi = 1'b0;
        w_slot  = 2'd0;
        case (seg_enable)
            4'b1110: begin w_legal = 1'b1; w_slot = 2'd0; end
            4'b1101: begin w_legal = 1'b1; w_slot = 2'd1; end
            4'b1011: begin w_legal = 1'b1; w_slot = 2'd2; end
            4'b0111: begin w_legal = 1'b1; w_slot = 2'd3; end
            4'b1111: begin w_legal = 1'b0; end
            default: begin w_multi = 1'b1; end
        endcase
    end

    // Illegal samples park the counter at zero so the next legal key always starts a fresh run.
    always_comb begin
        if (!w_legal)
            w_nextCount = 8'd0;
        else if (w_keyChanged)
            w_nextCount = 8'd1;
        else if (r_count >= STABLE_LIMIT)
            w_nextCount = STABLE_LIMIT;
        else
            w_nextCount = r_count + 8'd1;
    end

    assign w_startCommit = w_legal && (w_nextCount == STABLE_LIMIT) &&
                           (w_keyChanged || (r_count != STABLE_LIMIT));

    always_comb begin
        w_badPattern = 1'b0;
        w_nibble     = 4'hE;
        case (r_commitSeg[6:0])
            7'h40: w_nibble = 4'h0;
            7'h79: w_nibble = 4'h1;
            7'h24: w_nibble = 4'h2;
            7'h30: w_nibble = 4'h3;
            7'h19: w_nibble = 4'h4;
            7'h12: w_nibble = 4'h5;
            7'h02: w_nibble = 4'h6;
            7'h78: w_nibble = 4'h7;
            7'h00: w_nibble = 4'h8;
            7'h10: w_nibble = 4'h9;
            7'h7F: w_nibble = 4'hF;
            default: begin
                w_nibble     = 4'hE;
                w_badPattern = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_digitsNext = digits;
        w_digitsNext[{r_commitSlot, 2'b00} +: 4] = w_nibble;
    end

    assign w_seenNext   = r_seen | (4'b0001 << r_commitSlot);
    assign w_patternErr = r_commitPend && w_badPattern;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key        <= '1;
            r_count      <= '0;
            r_commitPend <= 1'b0;
            r_commitSlot <= 2'd0;
            r_commitSeg  <= '1;
        end else begin
            r_key        <= w_key;
            r_count      <= w_nextCount;
            r_commitPend <= w_startCommit;
            if (w_startCommit) begin
                r_commitSlot <= w_slot;
                r_commitSeg  <= seg_data;
            end
        end
    end

    // The frame completes on the commit that fills the seen-mask, snapshotting the post-commit digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen        <= '0;
            digits        <= '1;
            frame_digits  <= '1;
            dp            <= '0;
            digit_updated <= '0;
            frame_valid   <= 1'b0;
        end else begin
            digit_updated <= '0;
            frame_valid   <= 1'b0;
            if (r_commitPend) begin
                digits            <= w_digitsNext;
                dp[r_commitSlot]  <= ~r_commitSeg[7];
                digit_updated     <= 4'b0001 << r_commitSlot;
                if (w_seenNext == 4'hF) begin
                    frame_valid  <= 1'b1;
                    frame_digits <= w_digitsNext;
                    r_seen       <= '0;
                end else begin
                    r_seen <= w_seenNext;
                end
            end
        end
    end

    // A new error in the same cycle as err_clear keeps its flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pattern <= 1'b0;
            err_enable  <= 1'b0;
        end else begin
            if (w_patternErr)
                err_pattern <= 1'b1;
            else if (err_clear)
                err_pattern <= 1'b0;

            if (w_multi)
                err_enable <= 1'b1;
            else if (err_clear)
                err_enable <= 1'b0;
        end
    end

endmodule
